// File: rtl/dbus_responder.sv
// CPU data-bus target: zero-latency word RAM plus an MMIO block with a free-running
// cycle counter, a compare timer with interrupt, and an LED register.
module dbus_responder #(
    parameter int                         DATA_DBUS_WIDTH = 32,
    parameter int                         ADDR_DBUS_WIDTH = 32,
    parameter int                         RAM_DEPTH       = 1024,
    parameter logic [ADDR_DBUS_WIDTH-1:0] MMIO_BASE       = 32'hF000_0000
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [ADDR_DBUS_WIDTH-1:0] i_addr,
    input  logic                       i_we,
    input  logic [DATA_DBUS_WIDTH-1:0] i_wr_data,
    output logic [DATA_DBUS_WIDTH-1:0] o_rd_data,
    output logic [7:0]                 o_led,
    output logic                       o_irq,
    output logic                       o_err
);

    localparam int DW    = DATA_DBUS_WIDTH;
    localparam int AW    = ADDR_DBUS_WIDTH;
    localparam int IDX_W = $clog2(RAM_DEPTH);

    localparam logic [9:0] SEL_CYCLE = 10'd0;
    localparam logic [9:0] SEL_CMP   = 10'd1;
    localparam logic [9:0] SEL_CTRL  = 10'd2;
    localparam logic [9:0] SEL_LED   = 10'd3;
    localparam logic [9:0] SEL_TCNT  = 10'd4;

    logic [DW-1:0] mem [RAM_DEPTH];

    logic [DW-1:0] cycle_cnt;
    logic [DW-1:0] cmp_q;
    logic [DW-1:0] tcnt_q;
    logic          en_q;
    logic          irq_en_q;
    logic          flag_q;
    logic [7:0]    led_q;
    logic          err_p1;

    logic [IDX_W-1:0] ram_idx_p0;
    logic [9:0]       mmio_sel_p0;
    logic             is_ram_p0;
    logic             is_mmio_p0;
    logic             unmapped_p0;
    logic             wr_cmp_p0;
    logic             wr_ctrl_p0;
    logic             wr_led_p0;
    logic             tmr_match;
    logic             en_rise;
    logic             flag_clr;
    logic             unused_addr_bits;

    function automatic logic [DW-1:0] pack_ctrl(input logic flag, input logic irq_en,
                                                input logic en);
        return {{(DW-3){1'b0}}, flag, irq_en, en};
    endfunction

    function automatic logic [DW-1:0] pack_led(input logic [7:0] led);
        return {{(DW-8){1'b0}}, led};
    endfunction

    // Stage p0: address decode, write strobes and combinational read mux
    assign ram_idx_p0  = i_addr[IDX_W+1:2];
    assign mmio_sel_p0 = i_addr[11:2];
    assign is_ram_p0   = (i_addr >> (IDX_W + 2)) == '0;
    assign is_mmio_p0  = !is_ram_p0 && (i_addr[AW-1:12] == MMIO_BASE[AW-1:12]);
    assign unmapped_p0 = !is_ram_p0 && !is_mmio_p0;

    assign wr_cmp_p0  = i_we && is_mmio_p0 && (mmio_sel_p0 == SEL_CMP);
    assign wr_ctrl_p0 = i_we && is_mmio_p0 && (mmio_sel_p0 == SEL_CTRL);
    assign wr_led_p0  = i_we && is_mmio_p0 && (mmio_sel_p0 == SEL_LED);

    assign unused_addr_bits = ^i_addr[1:0];

    assign tmr_match = en_q && (tcnt_q == cmp_q);
    assign en_rise   = wr_ctrl_p0 && i_wr_data[0] && !en_q;
    assign flag_clr  = wr_ctrl_p0 && i_wr_data[2];

    always_comb begin
        o_rd_data = '0;
        if (is_ram_p0) begin
            o_rd_data = mem[ram_idx_p0];
        end else if (is_mmio_p0) begin
            case (mmio_sel_p0)
                SEL_CYCLE: o_rd_data = cycle_cnt;
                SEL_CMP:   o_rd_data = cmp_q;
                SEL_CTRL:  o_rd_data = pack_ctrl(flag_q, irq_en_q, en_q);
                SEL_LED:   o_rd_data = pack_led(led_q);
                SEL_TCNT:  o_rd_data = tcnt_q;
                default:   o_rd_data = '0;
            endcase
        end
    end

    // RAM is not reset; writes are blocked while reset is held so a write in flight is lost
    always_ff @(posedge i_clk) begin
        if (i_rst && i_we && is_ram_p0) begin
            mem[ram_idx_p0] <= i_wr_data;
        end
    end

    // Stage p1: MMIO registers, counters and the registered error pulse
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cycle_cnt <= '0;
            cmp_q     <= '0;
            tcnt_q    <= '0;
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            flag_q    <= 1'b0;
            led_q     <= '0;
            err_p1    <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + DW'(1);
            err_p1    <= unmapped_p0;

            if (wr_cmp_p0) begin
                cmp_q <= i_wr_data;
            end
            if (wr_led_p0) begin
                led_q <= i_wr_data[7:0];
            end
            if (wr_ctrl_p0) begin
                en_q     <= i_wr_data[0];
                irq_en_q <= i_wr_data[1];
            end

            // A match in the same cycle as a write-1-to-clear keeps the flag set
            flag_q <= (flag_q && !flag_clr) || tmr_match;

            if (en_rise) begin
                tcnt_q <= '0;
            end else if (en_q) begin
                tcnt_q <= tmr_match ? '0 : tcnt_q + DW'(1);
            end
        end
    end

    assign o_led = led_q;
    assign o_irq = flag_q && irq_en_q;
    assign o_err = err_p1;

endmodule

// File: tb/tb_dbus_responder.sv
// Bench for dbus_responder: directed scenarios plus a randomized access stream
// checked against a register-level reference model of the bus map.
`timescale 1ns/1ps
module tb_dbus_responder;

    localparam logic [31:0] A_CYCLE = 32'hF000_0000;
    localparam logic [31:0] A_CMP   = 32'hF000_0004;
    localparam logic [31:0] A_CTRL  = 32'hF000_0008;
    localparam logic [31:0] A_LED   = 32'hF000_000C;
    localparam logic [31:0] A_TCNT  = 32'hF000_0010;

    logic        clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [31:0] i_addr = A_CYCLE;
    logic        i_we = 1'b0;
    logic [31:0] i_wr_data = '0;
    logic [31:0] o_rd_data;
    logic [7:0]  o_led;
    logic        o_irq;
    logic        o_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_cycle, m_cmp, m_tcnt;
    logic        m_en, m_irqen, m_flag, m_err;
    logic [7:0]  m_led;
    logic [31:0] m_mem [int];

    dbus_responder dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_addr    (i_addr),
        .i_we      (i_we),
        .i_wr_data (i_wr_data),
        .o_rd_data (o_rd_data),
        .o_led     (o_led),
        .o_irq     (o_irq),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    // 0 = RAM (first 4 KB), 1 = MMIO window, 2 = unmapped
    function automatic int region(input logic [31:0] a);
        if (a < 32'h0000_1000) return 0;
        if (a[31:12] == 20'hF0000) return 1;
        return 2;
    endfunction

    function automatic void model_reset();
        m_cycle = '0; m_cmp = '0; m_tcnt = '0;
        m_en = 1'b0; m_irqen = 1'b0; m_flag = 1'b0; m_err = 1'b0;
        m_led = '0;
    endfunction

    function automatic void model_step(input logic [31:0] a, input logic we, input logic [31:0] d);
        int          rg     = region(a);
        logic [11:0] off    = {a[11:2], 2'b00};
        logic        hit    = m_en && (m_tcnt == m_cmp);
        logic [31:0] tcnt_n = m_tcnt;
        logic        flag_n = m_flag;
        if (m_en) tcnt_n = hit ? 32'd0 : m_tcnt + 32'd1;
        if (hit) flag_n = 1'b1;
        else if (we && rg == 1 && off == 12'h008 && d[2]) flag_n = 1'b0;
        if (we && rg == 0) m_mem[int'(a[11:2])] = d;
        if (we && rg == 1) begin
            case (off)
                12'h004: m_cmp = d;
                12'h008: begin
                    if (!m_en && d[0]) tcnt_n = 32'd0;
                    m_en = d[0];
                    m_irqen = d[1];
                end
                12'h00C: m_led = d[7:0];
                default: ;
            endcase
        end
        m_tcnt = tcnt_n;
        m_flag = flag_n;
        m_cycle = m_cycle + 32'd1;
        m_err = (rg == 2);
    endfunction

    // bit 32 set when the model knows the value (unwritten RAM is unknown)
    function automatic logic [32:0] model_read(input logic [31:0] a);
        int          rg  = region(a);
        logic [11:0] off = {a[11:2], 2'b00};
        if (rg == 0) begin
            if (m_mem.exists(int'(a[11:2]))) return {1'b1, m_mem[int'(a[11:2])]};
            return 33'd0;
        end
        if (rg == 2) return {1'b1, 32'd0};
        case (off)
            12'h000: return {1'b1, m_cycle};
            12'h004: return {1'b1, m_cmp};
            12'h008: return {1'b1, 29'd0, m_flag, m_irqen, m_en};
            12'h00C: return {1'b1, 24'd0, m_led};
            12'h010: return {1'b1, m_tcnt};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d);
        i_addr = a; i_we = we; i_wr_data = d;
        @(posedge clk);
        model_step(a, we, d);
        @(negedge clk);
        i_we = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a);
        i_addr = a; i_we = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b0; i_addr = A_CYCLE;
        @(negedge clk); #1;
        n_tests++; if (o_led !== 8'h00) begin n_fail++; $display("FAIL reset_led got %h want 00", o_led); end
        n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", o_irq); end
        n_tests++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", o_err); end
        n_tests++; if (o_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_mmio got %h want 0", o_rd_data); end
        @(negedge clk);
        i_rst = 1'b1;
        model_reset();
        peek(A_CYCLE);
        n_tests++; if (o_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_first_cycle got %h want 0", o_rd_data); end
    endtask

    task automatic test_ram();
        drive(32'h10, 1'b1, 32'hDEAD_BEEF);
        peek(32'h10);
        n_tests++; if (o_rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_rd got %h want deadbeef", o_rd_data); end
        peek(32'h13);
        n_tests++; if (o_rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_rd_unaligned got %h want deadbeef", o_rd_data); end
        drive(32'h14, 1'b1, 32'h0BAD_F00D);
        drive(32'hFFC, 1'b1, 32'h5A5A_0FFC);
        peek(32'h10);
        n_tests++; if (o_rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_neighbour got %h want deadbeef", o_rd_data); end
        peek(32'hFFC);
        n_tests++; if (o_rd_data !== 32'h5A5A_0FFC) begin n_fail++; $display("FAIL ram_last_word got %h want 5a5a0ffc", o_rd_data); end
    endtask

    task automatic test_timer();
        drive(A_CMP, 1'b1, 32'd3);
        drive(A_CTRL, 1'b1, 32'h3);
        for (int i = 0; i < 3; i++) begin
            drive(32'h10, 1'b0, 32'h0);
            n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL timer_early_irq tick %0d got %b want 0", i, o_irq); end
        end
        drive(32'h10, 1'b0, 32'h0);
        n_tests++; if (o_irq !== 1'b1) begin n_fail++; $display("FAIL timer_irq got %b want 1", o_irq); end
        peek(A_TCNT);
        n_tests++; if (o_rd_data !== 32'd0) begin n_fail++; $display("FAIL timer_tcnt_wrap got %h want 0", o_rd_data); end
        peek(A_CTRL);
        n_tests++; if (o_rd_data !== 32'h7) begin n_fail++; $display("FAIL timer_ctrl_flag got %h want 7", o_rd_data); end
        drive(A_CTRL, 1'b1, 32'h7);
        n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL timer_w1c got %b want 0", o_irq); end
        peek(A_CTRL);
        n_tests++; if (o_rd_data !== 32'h3) begin n_fail++; $display("FAIL timer_ctrl_cleared got %h want 3", o_rd_data); end
        drive(32'h10, 1'b0, 32'h0);
        drive(32'h10, 1'b0, 32'h0);
        drive(A_CTRL, 1'b1, 32'h7);
        n_tests++; if (o_irq !== 1'b1) begin n_fail++; $display("FAIL timer_set_wins got %b want 1", o_irq); end
        drive(A_CTRL, 1'b1, 32'h4);
        peek(A_CTRL);
        n_tests++; if (o_rd_data !== 32'h0) begin n_fail++; $display("FAIL timer_disable got %h want 0", o_rd_data); end
        drive(A_CMP, 1'b1, 32'd0);
        drive(A_CTRL, 1'b1, 32'h1);
        drive(32'h10, 1'b0, 32'h0);
        peek(A_TCNT);
        n_tests++; if (o_rd_data !== 32'd0) begin n_fail++; $display("FAIL timer_cmp0_tcnt got %h want 0", o_rd_data); end
        drive(A_CTRL, 1'b1, 32'h5);
        peek(A_CTRL);
        n_tests++; if (o_rd_data !== 32'h5) begin n_fail++; $display("FAIL timer_cmp0_flag got %h want 5", o_rd_data); end
        drive(A_CTRL, 1'b1, 32'h4);
        drive(A_CTRL, 1'b1, 32'h4);
        peek(A_CTRL);
        n_tests++; if (o_rd_data !== 32'h0) begin n_fail++; $display("FAIL timer_final_clear got %h want 0", o_rd_data); end
    endtask

    task automatic test_cycle();
        logic [31:0] c0, c1;
        drive(32'h10, 1'b0, 32'h0);
        peek(A_CYCLE);
        c0 = o_rd_data;
        n_tests++; if (c0 !== m_cycle) begin n_fail++; $display("FAIL cycle_value got %h want %h", c0, m_cycle); end
        repeat (10) drive(32'h10, 1'b0, 32'h0);
        peek(A_CYCLE);
        c1 = o_rd_data;
        n_tests++; if (c1 - c0 !== 32'd10) begin n_fail++; $display("FAIL cycle_delta got %0d want 10", c1 - c0); end
        drive(A_CYCLE, 1'b1, 32'h1234_5678);
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        release dut.cycle_cnt;
        m_cycle = 32'hFFFF_FFFF;
        peek(A_CYCLE);
        n_tests++; if (o_rd_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cycle_preset got %h want ffffffff", o_rd_data); end
        drive(32'h10, 1'b0, 32'h0);
        peek(A_CYCLE);
        n_tests++; if (o_rd_data !== 32'h0) begin n_fail++; $display("FAIL cycle_wrap got %h want 0", o_rd_data); end
    endtask

    task automatic test_decode();
        drive(A_LED, 1'b1, 32'h1A5);
        n_tests++; if (o_led !== 8'hA5) begin n_fail++; $display("FAIL led_out got %h want a5", o_led); end
        peek(A_LED);
        n_tests++; if (o_rd_data !== 32'hA5) begin n_fail++; $display("FAIL led_rd got %h want a5", o_rd_data); end
        drive(32'h0, 1'b1, 32'hCAFE_F00D);
        drive(32'h8000_0000, 1'b1, 32'h1234_5678);
        n_tests++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse got %b want 1", o_err); end
        peek(32'h8000_0000);
        n_tests++; if (o_rd_data !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd got %h want 0", o_rd_data); end
        drive(32'h0, 1'b0, 32'h0);
        n_tests++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle got %b want 0", o_err); end
        peek(32'h0);
        n_tests++; if (o_rd_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL ram_untouched got %h want cafef00d", o_rd_data); end
        drive(32'hF000_0020, 1'b1, 32'hFFFF_FFFF);
        n_tests++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL mmio_hole_err got %b want 0", o_err); end
        peek(32'hF000_0020);
        n_tests++; if (o_rd_data !== 32'h0) begin n_fail++; $display("FAIL mmio_hole_rd got %h want 0", o_rd_data); end
        drive(32'h0000_1000, 1'b0, 32'h0);
        n_tests++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL ram_edge_err got %b want 1", o_err); end
        drive(A_TCNT, 1'b1, 32'h0000_0055);
        peek(A_TCNT);
        n_tests++; if (o_rd_data !== m_tcnt) begin n_fail++; $display("FAIL tcnt_ro got %h want %h", o_rd_data, m_tcnt); end
    endtask

    task automatic test_async_reset();
        drive(A_LED, 1'b1, 32'h3C);
        drive(32'h40, 1'b1, 32'h1111_1111);
        drive(A_CMP, 1'b1, 32'd5);
        drive(A_CTRL, 1'b1, 32'h3);
        drive(32'h10, 1'b0, 32'h0);
        drive(32'h8000_0000, 1'b0, 32'h0);
        peek(A_TCNT);
        n_tests++; if (o_rd_data !== 32'd2) begin n_fail++; $display("FAIL arst_pre_tcnt got %h want 2", o_rd_data); end
        i_rst = 1'b0;
        #1;
        n_tests++; if (o_led !== 8'h00) begin n_fail++; $display("FAIL arst_led got %h want 00", o_led); end
        n_tests++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL arst_err got %b want 0", o_err); end
        peek(A_TCNT);
        n_tests++; if (o_rd_data !== 32'd0) begin n_fail++; $display("FAIL arst_tcnt got %h want 0", o_rd_data); end
        peek(A_CMP);
        n_tests++; if (o_rd_data !== 32'd0) begin n_fail++; $display("FAIL arst_cmp got %h want 0", o_rd_data); end
        i_addr = 32'h40; i_we = 1'b1; i_wr_data = 32'h2222_2222;
        @(posedge clk);
        @(negedge clk);
        i_we = 1'b0;
        i_rst = 1'b1;
        model_reset();
        peek(32'h40);
        n_tests++; if (o_rd_data !== 32'h1111_1111) begin n_fail++; $display("FAIL arst_write_lost got %h want 11111111", o_rd_data); end
        peek(A_CTRL);
        n_tests++; if (o_rd_data !== 32'h0) begin n_fail++; $display("FAIL arst_ctrl got %h want 0", o_rd_data); end
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic        we;
        logic [32:0] exp_rd;
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                4, 5, 6, 7: a = 32'hF000_0000 | ($urandom_range(0, 6) << 2);
                8: a = 32'h0000_0FFC;
                default: begin
                    case ($urandom_range(0, 3))
                        0: a = 32'h0000_1000;
                        1: a = 32'hF000_1000;
                        2: a = 32'hEFFF_FFFC;
                        default: a = {$urandom_range(4, 14), 28'h0} | ($urandom & 32'h0FFF_FFFC);
                    endcase
                end
            endcase
            we = ($urandom_range(0, 2) == 0);
            if (a == A_CMP) d = $urandom_range(0, 5);
            else if (a == A_CTRL) d = $urandom_range(0, 7);
            else d = $urandom;
            i_addr = a; i_we = we; i_wr_data = d;
            #1;
            exp_rd = model_read(a);
            if (exp_rd[32]) begin
                n_tests++;
                if (o_rd_data !== exp_rd[31:0]) begin
                    n_fail++;
                    $display("FAIL rand_rd it %0d addr %h got %h want %h", it, a, o_rd_data, exp_rd[31:0]);
                end
            end
            @(posedge clk);
            model_step(a, we, d);
            @(negedge clk);
            i_we = 1'b0;
            #1;
            n_tests++; if (o_led !== m_led) begin n_fail++; $display("FAIL rand_led it %0d got %h want %h", it, o_led, m_led); end
            n_tests++; if (o_irq !== (m_flag & m_irqen)) begin n_fail++; $display("FAIL rand_irq it %0d got %b want %b", it, o_irq, m_flag & m_irqen); end
            n_tests++; if (o_err !== m_err) begin n_fail++; $display("FAIL rand_err it %0d got %b want %b", it, o_err, m_err); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ram();
        test_timer();
        test_cycle();
        test_decode();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
